codec_frame_capture: RTL
========================

Name: codec_frame_capture

Overview:
- Parametrised multi-channel successor to the I2S channel-select capture buffer.
- Runs in the bclk domain directly behind the I2S receiver.
- Selects one of N_CH channels, optionally decimates, and captures a fixed-length frame of 2^ADDR_BITS samples into an internal RAM.
- Presents the frame to the FFT/display reader through a ready/ack handshake, in single-shot or continuous re-arm mode, with overrun detection.

Parameters:
- DATA_BITS, 16, sample width.
- ADDR_BITS, 10, frame depth = 2^ADDR_BITS samples.
- N_CH, 2, number of input channels; CH_BITS = max(1, clog2(N_CH)) is a derived localparam.
- DECIM_BITS, 4, width of the decimation control.

Ports:
- bclk  in  1  capture clock; all logic on posedge.
- req_rstn  in  1  reset, asynchronous, active-low.
- sample_data_i  in  N_CH*DATA_BITS  packed channel samples; channel k at bits [k*DATA_BITS +: DATA_BITS].
- data_ready_i  in  1  one-bclk pulse per new sample set.
- chann_sel_i  in  CH_BITS  channel to capture.
- mode_i  in  1  0 = single-shot, 1 = continuous.
- decim_i  in  DECIM_BITS  keep 1 of every decim_i+1 data_ready pulses.
- arm_i  in  1  start capture.
- frame_ack_i  in  1  reader releases the frame.
- rd_en_i  in  1  read request.
- rd_addr_i  in  ADDR_BITS  read address.
- rd_data_o  out  DATA_BITS  read data.
- rd_valid_o  out  1  rd_data_o valid pulse.
- frame_ready_o  out  1  frame complete and held.
- busy_o  out  1  capture in progress.
- wr_count_o  out  ADDR_BITS+1  samples written in the current frame.
- overrun_o  out  1  sticky: samples lost while a frame was held.

Behaviour:
- Reset (async, req_rstn=0):
  - State goes to IDLE; all counters 0.
  - rd_data_o=0, rd_valid_o=0, frame_ready_o=0, busy_o=0, wr_count_o=0, overrun_o=0.
  - RAM contents are not cleared.
  - Reset mid-frame aborts the frame; the next capture requires arm_i.
- FSM states: IDLE, FILL, READY.
  - IDLE -> FILL on arm_i. That cycle: latch chann_sel_i, mode_i and decim_i; clear wr_addr, decim counter and overrun_o.
  - FILL -> READY on the cycle the sample at address 2^ADDR_BITS-1 is written. frame_ready_o=1 from the next cycle.
  - READY + frame_ack_i, latched mode=0: go to IDLE.
  - READY + frame_ack_i, latched mode=1: go to FILL. wr_addr and decim counter clear; overrun_o is kept.
- arm_i is ignored outside IDLE. frame_ack_i is ignored outside READY.
- Channel, mode and decimation changes take effect only at the next arm.
- A data_ready_i pulse in the same cycle as arm_i or frame_ack_i is not captured; capture starts on the next pulse.
- Decimation (in FILL):
  - Each data_ready_i pulse increments the decim counter.
  - The sample is accepted when counter == latched decim, and the counter then returns to 0.
  - decim=0 accepts every pulse.
- An accepted sample writes sample_data_i[sel] to RAM[wr_addr] at that edge; wr_addr and wr_count_o increment.
  - wr_count_o reaches 2^ADDR_BITS on completion and holds that value in READY.
  - wr_count_o returns to 0 on leaving READY.
- busy_o = (state==FILL).
- Overrun: in READY, any decimation-accepted pulse sets overrun_o. In IDLE, pulses are ignored and do not set overrun_o.
- Reads:
  - Synchronous, 1-cycle latency: rd_en_i at edge N gives rd_data_o = RAM[rd_addr_i] and rd_valid_o=1 after edge N+1.
  - Reads are served only in READY. In other states rd_valid_o=0 and rd_data_o holds its last value.
  - rd_en_i together with frame_ack_i in the same cycle is served from the held frame.
  - No write occurs in READY, so a held frame is stable.
- Widths: wr_addr is ADDR_BITS and wraps only at frame completion. A chann_sel_i value >= N_CH selects channel 0.

Test Plan:
- ADDR_BITS=3, N_CH=2, sel=1, decim=0, single-shot. Arm, then 8 pulses with R samples 0x0100..0x0107 -> frame_ready_o=1 after the 8th write, busy_o=0. Reads of addr 0..7 return 0x0100..0x0107, each with rd_valid_o 1 cycle after rd_en_i. Ack -> IDLE, frame_ready_o=0.
- decim=2, sel=0: 24 pulses with L = pulse index 0..23 -> RAM holds 2,5,8,...,23; wr_count_o=8.
- Continuous mode: after frame 1 completes, send 3 pulses before ack -> overrun_o=1. Ack -> FILL, overrun_o stays 1. Next arm after the return to IDLE clears it.
- Arm and data_ready_i in the same cycle -> that sample is not stored; wr_count_o=0 until the next pulse.
- Drop req_rstn after 5 of 8 writes -> all outputs 0 immediately. A subsequent data_ready_i without arm -> no write, wr_count_o=0.
- arm_i in FILL and frame_ack_i in FILL -> no effect: wr_count_o continues and the frame completes normally. rd_en_i in FILL -> rd_valid_o stays 0.

Source files
------------

// File: rtl/codec_frame_capture.sv
// Channel-select frame capture buffer behind the I2S receiver: decimates one channel into a
// 2^ADDR_BITS sample RAM and holds the completed frame for the reader until acknowledged.
module codec_frame_capture #(
  parameter int unsigned DATA_BITS  = 16,
  parameter int unsigned ADDR_BITS  = 10,
  parameter int unsigned N_CH       = 2,
  parameter int unsigned DECIM_BITS = 4,
  localparam int unsigned CH_BITS   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                      bclk,
  input  logic                      req_rstn,
  input  logic [N_CH*DATA_BITS-1:0] sample_data_i,
  input  logic                      data_ready_i,
  input  logic [CH_BITS-1:0]        chann_sel_i,
  input  logic                      mode_i,
  input  logic [DECIM_BITS-1:0]     decim_i,
  input  logic                      arm_i,
  input  logic                      frame_ack_i,
  input  logic                      rd_en_i,
  input  logic [ADDR_BITS-1:0]      rd_addr_i,
  output logic [DATA_BITS-1:0]      rd_data_o,
  output logic                      rd_valid_o,
  output logic                      frame_ready_o,
  output logic                      busy_o,
  output logic [ADDR_BITS:0]        wr_count_o,
  output logic                      overrun_o
);

  localparam int unsigned Depth = 2 ** ADDR_BITS;

  typedef enum logic [1:0] {StIdle, StFill, StReady} state_e;

  state_e                state_q, state_d;
  logic [CH_BITS-1:0]    sel_q;
  logic                  mode_q;
  logic [DECIM_BITS-1:0] decim_q;
  logic [DECIM_BITS-1:0] decim_cnt_q;
  logic [ADDR_BITS-1:0]  wr_addr_q;
  logic [ADDR_BITS:0]    wr_count_q;
  logic                  overrun_q;
  logic [DATA_BITS-1:0]  rd_data_q;
  logic                  rd_valid_q;

  logic [DATA_BITS-1:0]  mem [Depth];
  logic [DATA_BITS-1:0]  sel_sample;

  logic start_fill;
  logic leave_ready;
  logic pulse_acc;
  logic wr_en;
  logic rd_serve;

  // Control strobes. Arm and ack cycles never capture a coincident data_ready pulse.
  always_comb begin
    state_d     = state_q;
    start_fill  = 1'b0;
    leave_ready = 1'b0;
    pulse_acc   = 1'b0;
    wr_en       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (arm_i) begin
          state_d    = StFill;
          start_fill = 1'b1;
        end
      end
      StFill: begin
        pulse_acc = data_ready_i && (decim_cnt_q == decim_q);
        wr_en     = pulse_acc;
        if (wr_en && (wr_addr_q == '1)) begin
          state_d = StReady;
        end
      end
      StReady: begin
        if (frame_ack_i) begin
          leave_ready = 1'b1;
          state_d     = mode_q ? StFill : StIdle;
        end else begin
          pulse_acc = data_ready_i && (decim_cnt_q == decim_q);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign rd_serve = rd_en_i && (state_q == StReady);

  always_comb begin
    sel_sample = sample_data_i[DATA_BITS-1:0];
    for (int k = 1; k < int'(N_CH); k++) begin
      if (sel_q == CH_BITS'(k)) begin
        sel_sample = sample_data_i[k*DATA_BITS +: DATA_BITS];
      end
    end
  end

  always_ff @(posedge bclk or negedge req_rstn) begin
    if (!req_rstn) begin
      state_q     <= StIdle;
      sel_q       <= '0;
      mode_q      <= 1'b0;
      decim_q     <= '0;
      decim_cnt_q <= '0;
      wr_addr_q   <= '0;
      wr_count_q  <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q <= state_d;

      if (start_fill) begin
        // Out-of-range channel requests fall back to channel 0.
        sel_q   <= (32'(chann_sel_i) < N_CH) ? chann_sel_i : '0;
        mode_q  <= mode_i;
        decim_q <= decim_i;
      end

      if (start_fill || leave_ready) begin
        decim_cnt_q <= '0;
      end else if ((state_q != StIdle) && data_ready_i) begin
        decim_cnt_q <= pulse_acc ? '0 : decim_cnt_q + 1'b1;
      end

      // wr_addr wraps back to 0 naturally on the final write of a frame.
      if (start_fill || leave_ready) begin
        wr_addr_q  <= '0;
        wr_count_q <= '0;
      end else if (wr_en) begin
        wr_addr_q  <= wr_addr_q + 1'b1;
        wr_count_q <= wr_count_q + 1'b1;
      end

      if (start_fill) begin
        overrun_q <= 1'b0;
      end else if ((state_q == StReady) && pulse_acc) begin
        overrun_q <= 1'b1;
      end
    end
  end

  // Frame storage is intentionally not reset.
  always_ff @(posedge bclk) begin
    if (wr_en) begin
      mem[wr_addr_q] <= sel_sample;
    end
  end

  always_ff @(posedge bclk or negedge req_rstn) begin
    if (!req_rstn) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= rd_serve;
      if (rd_serve) begin
        rd_data_q <= mem[rd_addr_i];
      end
    end
  end

  assign rd_data_o     = rd_data_q;
  assign rd_valid_o    = rd_valid_q;
  assign frame_ready_o = (state_q == StReady);
  assign busy_o        = (state_q == StFill);
  assign wr_count_o    = wr_count_q;
  assign overrun_o     = overrun_q;

endmodule
